// File: rtl/seq_minmax_pkg.sv
// -----------------------------------------------------------------------------
// seq_minmax_pkg
// Shared types for the sequential min/max tracker.
//   state_e : frame FSM state. COLLECT accepts samples; DONE presents the
//             frame result until it is taken or the frame is aborted.
// -----------------------------------------------------------------------------
package seq_minmax_pkg;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_e;

endpackage : seq_minmax_pkg

// File: rtl/seq_minmax_tracker_minmax_cmp.sv
// -----------------------------------------------------------------------------
// minmax_cmp
// Combinational update cell for the running min/max of a frame.
// Ports:
//   first        in   sample is the first of its frame (seed both trackers)
//   cur_min      in   WIDTH  running minimum so far
//   cur_max      in   WIDTH  running maximum so far
//   cur_min_idx  in   IDXW   position of the running minimum
//   cur_max_idx  in   IDXW   position of the running maximum
//   sample       in   WIDTH  new sample value (unsigned)
//   sample_idx   in   IDXW   position of the new sample in the frame
//   nxt_min      out  WIDTH  updated minimum
//   nxt_max      out  WIDTH  updated maximum
//   nxt_min_idx  out  IDXW   updated minimum position
//   nxt_max_idx  out  IDXW   updated maximum position
// Compares are strict, so on a tie the earlier position is kept.
// -----------------------------------------------------------------------------
module minmax_cmp
  import seq_minmax_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 2
) (
  input  logic             first,
  input  logic [WIDTH-1:0] cur_min,
  input  logic [WIDTH-1:0] cur_max,
  input  logic [IDXW-1:0]  cur_min_idx,
  input  logic [IDXW-1:0]  cur_max_idx,
  input  logic [WIDTH-1:0] sample,
  input  logic [IDXW-1:0]  sample_idx,
  output logic [WIDTH-1:0] nxt_min,
  output logic [WIDTH-1:0] nxt_max,
  output logic [IDXW-1:0]  nxt_min_idx,
  output logic [IDXW-1:0]  nxt_max_idx
);

  // Minimum side: seed on the first sample, otherwise replace only on a
  // strictly smaller value.
  always_comb begin
    nxt_min     = cur_min;
    nxt_min_idx = cur_min_idx;
    if (first) begin
      nxt_min     = sample;
      nxt_min_idx = '0;
    end else if (sample < cur_min) begin
      nxt_min     = sample;
      nxt_min_idx = sample_idx;
    end else begin
      nxt_min     = cur_min;
      nxt_min_idx = cur_min_idx;
    end
  end

  // Maximum side: seed on the first sample, otherwise replace only on a
  // strictly larger value.
  always_comb begin
    nxt_max     = cur_max;
    nxt_max_idx = cur_max_idx;
    if (first) begin
      nxt_max     = sample;
      nxt_max_idx = '0;
    end else if (sample > cur_max) begin
      nxt_max     = sample;
      nxt_max_idx = sample_idx;
    end else begin
      nxt_max     = cur_max;
      nxt_max_idx = cur_max_idx;
    end
  end

endmodule : minmax_cmp

// File: rtl/seq_minmax_tracker.sv
// -----------------------------------------------------------------------------
// seq_minmax_tracker
// Collects a frame of N unsigned samples over a valid/ready input stream,
// tracks the minimum and maximum (with first-occurrence positions) and
// presents the frame result over a valid/ready output port.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (priority over clr)
//   clr        in   synchronous frame abort, active-high
//   in_valid   in   sample valid
//   in_ready   out  block can accept a sample (COLLECT state)
//   in_data    in   WIDTH sample value
//   out_valid  out  frame result valid (DONE state)
//   out_ready  in   consumer accepts result
//   min        out  WIDTH smallest sample of the frame
//   max        out  WIDTH largest sample of the frame
//   min_idx    out  IDXW  first position of min
//   max_idx    out  IDXW  first position of max
// All outputs come straight from flops or a decode of the state flop; there
// is no combinational path from in_data to any output.
// -----------------------------------------------------------------------------
module seq_minmax_tracker
  import seq_minmax_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N     = 4,
  localparam int unsigned IDXW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max,
  output logic [IDXW-1:0]  min_idx,
  output logic [IDXW-1:0]  max_idx
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_e           state_q,   state_d;
  logic [IDXW-1:0]  count_q,   count_d;
  logic [WIDTH-1:0] min_q,     min_d;
  logic [WIDTH-1:0] max_q,     max_d;
  logic [IDXW-1:0]  min_idx_q, min_idx_d;
  logic [IDXW-1:0]  max_idx_q, max_idx_d;

  logic             accept_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] cmp_min_s;
  logic [WIDTH-1:0] cmp_max_s;
  logic [IDXW-1:0]  cmp_min_idx_s;
  logic [IDXW-1:0]  cmp_max_idx_s;

  assign accept_s = in_valid & in_ready_s;

  minmax_cmp #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_cmp (
    .first       (count_q == '0),
    .cur_min     (min_q),
    .cur_max     (max_q),
    .cur_min_idx (min_idx_q),
    .cur_max_idx (max_idx_q),
    .sample      (in_data),
    .sample_idx  (count_q),
    .nxt_min     (cmp_min_s),
    .nxt_max     (cmp_max_s),
    .nxt_min_idx (cmp_min_idx_s),
    .nxt_max_idx (cmp_max_idx_s)
  );

  // State, count and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      count_q   <= '0;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
    end
  end

  // Next-state logic: clr aborts from any state and beats a simultaneous
  // accept or output handshake. Result registers keep their last value on
  // abort; they are simply not valid.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    if (clr) begin
      state_d = ST_COLLECT;
      count_d = '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept_s) begin
            min_d     = cmp_min_s;
            max_d     = cmp_max_s;
            min_idx_d = cmp_min_idx_s;
            max_idx_d = cmp_max_idx_s;
            if (count_q == LAST_IDX) begin
              state_d = ST_DONE;
              count_d = '0;
            end else begin
              state_d = ST_COLLECT;
              count_d = count_q + IDXW'(1);
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_COLLECT;
          count_d = '0;
        end
      endcase
    end
  end

  // Handshake outputs are a pure decode of the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_DONE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign min       = min_q;
  assign max       = max_q;
  assign min_idx   = min_idx_q;
  assign max_idx   = max_idx_q;

endmodule : seq_minmax_tracker
